// File: rtl/decode_execute_unit.sv
// Decode, operand-select and execute stage of the sequential RV64 core with one
// registered output stage. Define BNE_SUPPORT_EN to decode funct3=001 branches as bne.
module decode_execute_unit #(
    parameter int XLEN    = 64,
    parameter int PC_STEP = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            valid_in,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            valid_out,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      rd_addr,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_to_reg,
    output logic [XLEN-1:0] next_pc,
    output logic            branch_taken,
    output logic            x0_write,
    output logic            inv_op,
    output logic            inv_func,
    output logic            halt
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_op_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_field;

    assign opcode   = instruction[6:0];
    assign funct3   = instruction[14:12];
    assign funct7   = instruction[31:25];
    assign rd_field = instruction[11:7];
    assign rs1_addr = instruction[19:15];
    assign rs2_addr = instruction[24:20];

    alu_op_t alu_op;
    logic    alu_src_imm;
    logic    use_s_imm;
    logic    dec_reg_write;
    logic    dec_mem_read;
    logic    dec_mem_write;
    logic    dec_mem_to_reg;
    logic    is_branch;
    logic    branch_on_ne;
    logic    dec_inv_op;
    logic    dec_inv_func;

    always_comb begin
        alu_op         = ALU_ADD;
        alu_src_imm    = 1'b0;
        use_s_imm      = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        is_branch      = 1'b0;
        branch_on_ne   = 1'b0;
        dec_inv_op     = 1'b0;
        dec_inv_func   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_reg_write = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: alu_op = ALU_ADD;
                    10'b0100000_000: alu_op = ALU_SUB;
                    10'b0000000_111: alu_op = ALU_AND;
                    10'b0000000_110: alu_op = ALU_OR;
                    default:         dec_inv_func = 1'b1;
                endcase
            end
            OP_LOAD: begin
                alu_src_imm    = 1'b1;
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_inv_func   = (funct3 != 3'b011);
            end
            OP_STORE: begin
                alu_src_imm   = 1'b1;
                use_s_imm     = 1'b1;
                dec_mem_write = 1'b1;
                dec_inv_func  = (funct3 != 3'b011);
            end
            OP_BRANCH: begin
                alu_op    = ALU_SUB;
                is_branch = 1'b1;
                case (funct3)
                    3'b000:  branch_on_ne = 1'b0;
`ifdef BNE_SUPPORT_EN
                    3'b001:  branch_on_ne = 1'b1;
`endif
                    default: dec_inv_func = 1'b1;
                endcase
            end
            default: dec_inv_op = 1'b1;
        endcase
    end

    // One flag at most per instruction: halt outranks inv_op, which outranks inv_func.
    logic halt_d;
    logic inv_op_d;
    logic inv_func_d;
    logic any_err;

    assign halt_d     = (instruction == 32'hFFFF_FFFF);
    assign inv_op_d   = !halt_d && dec_inv_op;
    assign inv_func_d = !halt_d && !dec_inv_op && dec_inv_func;
    assign any_err    = halt_d || dec_inv_op || dec_inv_func;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;

    assign imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
    assign imm_s = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_out;

    assign op_a = rs1_data;
    assign op_b = alu_src_imm ? (use_s_imm ? imm_s : imm_i) : rs2_data;

    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_AND: alu_out = op_a & op_b;
            ALU_OR:  alu_out = op_a | op_b;
            ALU_ADD: alu_out = op_a + op_b;
            ALU_SUB: alu_out = op_a - op_b;
            default: alu_out = '0;
        endcase
    end

    logic            alu_zero;
    logic            take_d;
    logic            write_class;
    logic [XLEN-1:0] next_pc_d;

    assign alu_zero    = (alu_out == '0);
    assign take_d      = is_branch && !any_err && (branch_on_ne ? !alu_zero : alu_zero);
    assign write_class = dec_reg_write && !any_err;

    always_comb begin
        next_pc_d = pc + XLEN'(PC_STEP);
        if (any_err) begin
            next_pc_d = pc;
        end else if (take_d) begin
            next_pc_d = pc + imm_b;
        end
    end

    // Data outputs hold across bubbles; strobes and flags drop to zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_out    <= 1'b0;
            alu_result   <= '0;
            store_data   <= '0;
            rd_addr      <= '0;
            next_pc      <= '0;
            mem_to_reg   <= 1'b0;
            reg_write    <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            branch_taken <= 1'b0;
            x0_write     <= 1'b0;
            inv_op       <= 1'b0;
            inv_func     <= 1'b0;
            halt         <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                alu_result   <= alu_out;
                store_data   <= rs2_data;
                rd_addr      <= rd_field;
                next_pc      <= next_pc_d;
                mem_to_reg   <= dec_mem_to_reg && !any_err;
                reg_write    <= write_class && (rd_field != 5'd0);
                x0_write     <= write_class && (rd_field == 5'd0);
                mem_read     <= dec_mem_read && !any_err;
                mem_write    <= dec_mem_write && !any_err;
                branch_taken <= take_d;
                inv_op       <= inv_op_d;
                inv_func     <= inv_func_d;
                halt         <= halt_d;
            end else begin
                reg_write    <= 1'b0;
                mem_read     <= 1'b0;
                mem_write    <= 1'b0;
                branch_taken <= 1'b0;
                x0_write     <= 1'b0;
                inv_op       <= 1'b0;
                inv_func     <= 1'b0;
                halt         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_execute_unit.sv
// Randomized bench for decode_execute_unit against an instruction-level reference model.
module tb_decode_execute_unit;

    logic        clock;
    logic        reset_n;
    logic        valid_in;
    logic [31:0] instruction;
    logic [63:0] pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        valid_out;
    logic [63:0] alu_result;
    logic [63:0] store_data;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [63:0] next_pc;
    logic        branch_taken;
    logic        x0_write;
    logic        inv_op;
    logic        inv_func;
    logic        halt;

    decode_execute_unit dut (
        .clock(clock), .reset_n(reset_n), .valid_in(valid_in),
        .instruction(instruction), .pc(pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .valid_out(valid_out), .alu_result(alu_result), .store_data(store_data),
        .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .next_pc(next_pc),
        .branch_taken(branch_taken), .x0_write(x0_write), .inv_op(inv_op),
        .inv_func(inv_func), .halt(halt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected registered outputs
    bit          e_valid, e_rw, e_mr, e_mw, e_m2r, e_bt, e_x0, e_iop, e_ifn, e_halt;
    bit          e_skip;
    logic [63:0] e_alu, e_store, e_npc;
    logic [4:0]  e_rd;

    task automatic model_reset();
        e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_m2r = 0; e_bt = 0;
        e_x0 = 0; e_iop = 0; e_ifn = 0; e_halt = 0; e_skip = 0;
        e_alu = '0; e_store = '0; e_npc = '0; e_rd = '0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] ins,
                              input logic [63:0] p, input logic [63:0] a, input logic [63:0] b);
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        longint      ii, is_, ib;
        logic [63:0] res;
        bit          wr, mr, mw, m2r, tk, iop, ifn, hlt;
        e_valid = v;
        e_rw = 0; e_mr = 0; e_mw = 0; e_bt = 0; e_x0 = 0; e_iop = 0; e_ifn = 0; e_halt = 0;
        if (!v) return;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        ii  = longint'($signed(ins[31:20]));
        is_ = longint'($signed({ins[31:25], ins[11:7]}));
        ib  = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        res = '0; wr = 0; mr = 0; mw = 0; m2r = 0; tk = 0; iop = 0; ifn = 0;
        hlt = (ins == 32'hFFFF_FFFF);
        case (op)
            7'b0110011: begin
                wr = 1;
                if      (f7 == 7'h00 && f3 == 3'd0) res = a + b;
                else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
                else if (f7 == 7'h00 && f3 == 3'd7) res = a & b;
                else if (f7 == 7'h00 && f3 == 3'd6) res = a | b;
                else ifn = 1;
            end
            7'b0000011: begin
                wr = 1; mr = 1; m2r = 1;
                res = a + $unsigned(ii);
                ifn = (f3 != 3'd3);
            end
            7'b0100011: begin
                mw = 1;
                res = a + $unsigned(is_);
                ifn = (f3 != 3'd3);
            end
            7'b1100011: begin
                res = a - b;
                if (f3 == 3'd0) tk = (res == 0);
`ifdef BNE_SUPPORT_EN
                else if (f3 == 3'd1) tk = (res != 0);
`endif
                else ifn = 1;
            end
            default: iop = 1;
        endcase
        if (hlt) begin iop = 0; ifn = 0; end
        if (iop) ifn = 0;
        e_halt = hlt; e_iop = iop; e_ifn = ifn;
        e_skip = hlt || iop || ifn;
        e_store = b;
        e_rd = ins[11:7];
        if (e_skip) begin
            e_npc = p;
        end else begin
            e_alu = res;
            e_m2r = m2r;
            e_mr = mr; e_mw = mw; e_bt = tk;
            e_npc = tk ? p + $unsigned(ib) : p + 64'd4;
            if (wr) begin
                if (ins[11:7] == 5'd0) e_x0 = 1;
                else                   e_rw = 1;
            end
        end
    endtask

    task automatic compare_outputs();
        check_val("valid_out",    64'(valid_out),    64'(e_valid));
        check_val("store_data",   store_data,        e_store);
        check_val("rd_addr",      64'(rd_addr),      64'(e_rd));
        check_val("next_pc",      next_pc,           e_npc);
        check_val("reg_write",    64'(reg_write),    64'(e_rw));
        check_val("mem_read",     64'(mem_read),     64'(e_mr));
        check_val("mem_write",    64'(mem_write),    64'(e_mw));
        check_val("branch_taken", 64'(branch_taken), 64'(e_bt));
        check_val("x0_write",     64'(x0_write),     64'(e_x0));
        check_val("inv_op",       64'(inv_op),       64'(e_iop));
        check_val("inv_func",     64'(inv_func),     64'(e_ifn));
        check_val("halt",         64'(halt),         64'(e_halt));
        if (!e_skip) begin
            check_val("alu_result", alu_result,      e_alu);
            check_val("mem_to_reg", 64'(mem_to_reg), 64'(e_m2r));
        end
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic step(input bit v, input logic [31:0] ins,
                        input logic [63:0] p, input logic [63:0] a, input logic [63:0] b);
        valid_in = v; instruction = ins; pc = p; rs1_data = a; rs2_data = b;
        #1;
        check_val("rs1_addr", 64'(rs1_addr), 64'(ins[19:15]));
        check_val("rs2_addr", 64'(rs2_addr), 64'(ins[24:20]));
        model_step(v, ins, p, a, b);
        @(negedge clock);
        compare_outputs();
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, r2, r1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, r1, f3, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {imm[11:5], r2, r1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [31:0] ins;
        logic [63:0] a, b, p;
        logic [4:0]  rd, r1, r2;
        logic [6:0]  bad_ops [5];
        bad_ops = '{7'h7F, 7'h13, 7'h37, 7'h6F, 7'h00};

        reset_n = 1'b0; valid_in = 1'b0; instruction = '0; pc = '0;
        rs1_data = '0; rs2_data = '0;
        model_reset();
        #3;
        compare_outputs();
        @(negedge clock);
        reset_n = 1'b1;

        step(1, 32'h002081B3, 64'h0, 64'd1, 64'd2);
        check_val("tp_add_result", alu_result, 64'd3);
        check_val("tp_add_npc", next_pc, 64'd4);
        step(1, 32'h402382B3, 64'h4, 64'd7, 64'd2);
        check_val("tp_sub_result", alu_result, 64'd5);
        step(1, enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd6), 64'h8, 64'hC, 64'hA);
        check_val("tp_and_result", alu_result, 64'h8);
        step(1, enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd6), 64'hC, 64'hC, 64'hA);
        check_val("tp_or_result", alu_result, 64'hE);
        step(1, 32'h00803203, 64'h10, 64'd0, 64'd99);
        check_val("tp_ld_result", alu_result, 64'd8);
        check_val("tp_ld_mem_read", 64'(mem_read), 64'd1);
        step(1, enc_s(12'd8, 5'd2, 5'd0, 3'd3), 64'h14, 64'd0, 64'h1234_5678_9ABC_DEF0);
        check_val("tp_sd_store", store_data, 64'h1234_5678_9ABC_DEF0);
        check_val("tp_sd_mem_write", 64'(mem_write), 64'd1);
        step(1, 32'h00108463, 64'h10, 64'd5, 64'd5);
        check_val("tp_beq_taken_npc", next_pc, 64'h18);
        step(1, 32'h00108463, 64'h10, 64'd5, 64'd6);
        check_val("tp_beq_not_taken_npc", next_pc, 64'h14);
        step(1, 32'h0000007F, 64'h20, 64'd1, 64'd2);
        check_val("tp_inv_op", 64'(inv_op), 64'd1);
        check_val("tp_inv_op_npc", next_pc, 64'h20);
        step(1, enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3), 64'h24, 64'd1, 64'd2);
        check_val("tp_inv_func", 64'(inv_func), 64'd1);
        step(1, 32'hFFFF_FFFF, 64'h28, 64'd1, 64'd2);
        check_val("tp_halt", 64'(halt), 64'd1);
        check_val("tp_halt_inv_op", 64'(inv_op), 64'd0);
        step(1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 64'h2C, 64'd1, 64'd2);
        check_val("tp_x0_write", 64'(x0_write), 64'd1);
        check_val("tp_x0_reg_write", 64'(reg_write), 64'd0);
        check_val("tp_x0_result", alu_result, 64'd3);
        step(1, 32'h00108463, 64'hFFFF_FFFF_FFFF_FFFC, 64'd5, 64'd6);
        check_val("tp_pc_wrap", next_pc, 64'h0);

        for (int n = 0; n < 300; n++) begin
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            r1 = 5'($urandom); r2 = 5'($urandom);
            a = rand64(); b = rand64();
            p = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : (rand64() & ~64'h3);
            case ($urandom_range(0, 11))
                0:  ins = enc_r(7'h00, r2, r1, 3'd0, rd);
                1:  ins = enc_r(7'h20, r2, r1, 3'd0, rd);
                2:  ins = enc_r(7'h00, r2, r1, 3'd7, rd);
                3:  ins = enc_r(7'h00, r2, r1, 3'd6, rd);
                4:  ins = enc_i(12'($urandom), r1, 3'd3, rd);
                5:  ins = enc_s(12'($urandom), r2, r1, 3'd3);
                6:  begin
                        ins = enc_b(13'($urandom), r2, r1, 3'd0);
                        if ($urandom_range(0, 1) == 1) b = a;
                    end
                7:  begin
                        ins = enc_b(13'($urandom), r2, r1, 3'd1);
                        if ($urandom_range(0, 1) == 1) b = a;
                    end
                8:  ins = {25'($urandom), bad_ops[$urandom_range(0, 4)]};
                9:  ins = enc_r(7'($urandom_range(1, 31)), r2, r1, 3'($urandom), rd);
                10: ins = 32'hFFFF_FFFF;
                default: begin
                    if ($urandom_range(0, 1) == 1)
                        ins = enc_i(12'($urandom), r1, 3'($urandom_range(0, 2)), rd);
                    else
                        ins = enc_s(12'($urandom), r2, r1, 3'($urandom_range(4, 7)));
                end
            endcase
            step(($urandom_range(0, 9) != 0), ins, p, a, b);

            if (n == 150) begin
                #2;
                reset_n = 1'b0;
                #1;
                model_reset();
                compare_outputs();
                @(negedge clock);
                reset_n = 1'b1;
                step(0, enc_i(12'd8, 5'd0, 3'd3, 5'd4), 64'h40, 64'd1, 64'd2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_execute_unit.md
Name: decode_execute_unit

Overview:
Combined decode, operand-select and execute stage of the sequential RV64 core. It decodes a 32-bit instruction, generates the immediate, selects the second ALU operand (register or immediate), performs the ALU operation, and computes the next PC. Results and control strobes are captured in an output register stage that feeds the memory-access and write-back logic. Register-file read addresses are driven combinationally, so read data returns in the same cycle.

Parameters:
XLEN, 64, datapath and PC width.
PC_STEP, 4, sequential PC increment in bytes.

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
valid_in  in  1  instruction/pc/operand inputs valid this cycle
instruction  in  32  instruction word from fetch
pc  in  XLEN  PC of instruction
rs1_addr  out  5  combinational, instruction[19:15]
rs2_addr  out  5  combinational, instruction[24:20]
rs1_data  in  XLEN  register-file read data for rs1_addr
rs2_data  in  XLEN  register-file read data for rs2_addr
valid_out  out  1  registered results valid
alu_result  out  XLEN  ALU output: result or memory address
store_data  out  XLEN  rs2_data captured for sd
rd_addr  out  5  destination register, instruction[11:7]
reg_write  out  1  write rd; forced 0 when rd_addr==0
mem_read  out  1  ld
mem_write  out  1  sd
mem_to_reg  out  1  write-back selects memory data
next_pc  out  XLEN  PC of next instruction
branch_taken  out  1  branch condition met
x0_write  out  1  decoded write to x0, suppressed
inv_op  out  1  unsupported opcode
inv_func  out  1  unsupported funct3/funct7
halt  out  1  instruction == 32'hFFFFFFFF

Behaviour:
- Reset (reset_n low, asynchronous): every registered output is 0, including next_pc. Reset has priority over every other event; reset asserted mid-operation clears all outputs immediately.
- Latency: one clock. Each rising edge registers the decode/execute result of the current inputs. valid_out <= valid_in.
- When valid_in=0, all strobes and flags are registered as 0: reg_write, mem_read, mem_write, branch_taken, x0_write, inv_op, inv_func, halt. Data outputs hold their previous values.
- Decode, opcode [6:0]:
  - 0110011 R-type, ALU code from {funct7,funct3}:
    - add 0000000/000 -> 0010
    - sub 0100000/000 -> 0110
    - and 0000000/111 -> 0000
    - or 0000000/110 -> 0001
  - 0000011 ld: funct3 must be 011. ALUSrc=imm, add, mem_read=1, mem_to_reg=1, reg_write=1.
  - 0100011 sd: funct3 must be 011. ALUSrc=imm, add, mem_write=1.
  - 1100011 beq: funct3 must be 000. ALU sub; branch when result==0.
- Immediates, all sign-extended to XLEN:
  - I-type: instruction[31:20].
  - S-type: {instruction[31:25], instruction[11:7]}.
  - B-type: {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}.
- Operand mux: opB = ALUSrc ? imm : rs2_data. opA = rs1_data.
- ALU arithmetic is XLEN-bit modulo 2^XLEN; overflow wraps with no flag.
- next_pc:
  - beq with zero result: pc + B-imm, branch_taken=1.
  - Otherwise: pc + PC_STEP. Wraps at 2^XLEN.
- Error and halt priority: halt > inv_op > inv_func.
  - Any of these suppresses reg_write, mem_read, mem_write and branch_taken.
  - next_pc = pc in those cases (hold PC).
  - Flags are per-instruction (not sticky).
- rd_addr==0 with a write-class instruction: reg_write=0, x0_write=1, alu_result still computed.
- store_data = rs2_data for every valid instruction.

Optional Feature:
BNE_SUPPORT_EN:
- Defined: opcode 1100011 with funct3 001 decodes as bne. ALU sub; branch when result != 0; same target computation as beq.
- Undefined: funct3 001 under opcode 1100011 sets inv_func=1.

Test Plan:
- add x3,x1,x2 (0x002081B3), pc=0, rs1_data=1, rs2_data=2 -> next edge: alu_result=3, rd_addr=3, reg_write=1, next_pc=4, valid_out=1.
- sub x5,x7,x2 (0x402382B3), rs1_data=7, rs2_data=2 -> alu_result=5. and/or with 0xC and 0xA -> 0x8 / 0xE.
- ld x4,8(x0) (0x00803203), rs1_data=0 -> alu_result=8, mem_read=1, mem_to_reg=1, reg_write=1, rd_addr=4. sd variant -> mem_write=1, store_data=rs2_data, reg_write=0.
- beq x1,x1,+8 (0x00108463), pc=0x10:
  - rs1_data=rs2_data=5 -> next_pc=0x18, branch_taken=1.
  - rs2_data=6 -> next_pc=0x14, branch_taken=0.
- Error and halt cases:
  - Opcode 0x7F -> inv_op=1, all strobes 0, next_pc=pc.
  - R-type funct7=0x01 -> inv_func=1.
  - 0xFFFFFFFF -> halt=1.
  - add x0,x1,x2 -> x0_write=1, reg_write=0.
- Assert reset_n low mid-stream, asynchronously between edges -> all outputs 0 immediately. Deassert, then valid_in=0 for one cycle -> valid_out=0 and strobes 0.
